// File: rtl/memp_load_sequencer.sv
// rtl/memp_load_sequencer.sv - packs a serial element stream into cluster words and writes them to the P-vector memory
// Optional feature: define MEMP_LOADER_FLUSH_EN to add the flush input (early termination of a load).
module memp_load_sequencer #(
    parameter int number_of_clusters              = 1,
    parameter int number_of_equations_per_cluster = 9,
    parameter int element_width                   = 64,
    parameter int address_width                   = 20
) (
    input  logic                                                     clk,
    input  logic                                                     rst_n,
    input  logic                                                     start,
    input  logic [element_width-1:0]                                 in_data,
    input  logic                                                     in_valid,
`ifdef MEMP_LOADER_FLUSH_EN
    input  logic                                                     flush,
`endif
    output logic                                                     in_ready,
    output logic [number_of_equations_per_cluster*element_width-1:0] mem_write_data,
    output logic                                                     mem_write_enable,
    output logic [address_width-1:0]                                 mem_write_address,
    output logic                                                     busy,
    output logic                                                     done
);

    localparam int n  = number_of_equations_per_cluster;
    localparam int w  = element_width;
    localparam int kw = (n > 1) ? $clog2(n) : 1;
    localparam logic [kw-1:0]            last_k       = kw'(n - 1);
    localparam logic [address_width-1:0] last_cluster = address_width'(number_of_clusters - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                   state;
    logic [kw-1:0]            k;
    logic [address_width-1:0] cluster;
    logic [n*w-1:0]           pack;
    logic [n*w-1:0]           pack_next;
    logic                     transfer;
    logic                     final_write;

    assign in_ready = (state == FILL);
    assign transfer = in_valid & in_ready;

    // Word as it will look once the element offered this cycle is stored.
    always_comb begin
        pack_next = pack;
        pack_next[k*w +: w] = in_data;
    end

`ifdef MEMP_LOADER_FLUSH_EN
    logic flushed;
    assign final_write = (cluster == last_cluster) || flushed;
`else
    assign final_write = (cluster == last_cluster);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            k                 <= '0;
            cluster           <= '0;
            pack              <= '0;
            mem_write_data    <= '0;
            mem_write_enable  <= 1'b0;
            mem_write_address <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
`ifdef MEMP_LOADER_FLUSH_EN
            flushed           <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FILL;
                        busy    <= 1'b1;
                        k       <= '0;
                        cluster <= '0;
                        pack    <= '0;
`ifdef MEMP_LOADER_FLUSH_EN
                        flushed <= 1'b0;
`endif
                    end
                end
                FILL: begin
                    if (transfer) begin
                        pack <= pack_next;
                        if (k == last_k) begin
                            state             <= WRITE;
                            mem_write_enable  <= 1'b1;
                            mem_write_address <= cluster;
                            mem_write_data    <= pack_next;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
`ifdef MEMP_LOADER_FLUSH_EN
                    // Unfilled slots are already zero because pack is cleared per cluster.
                    else if (flush) begin
                        if (k != '0) begin
                            state             <= WRITE;
                            mem_write_enable  <= 1'b1;
                            mem_write_address <= cluster;
                            mem_write_data    <= pack;
                            flushed           <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
`endif
                end
                WRITE: begin
                    mem_write_enable <= 1'b0;
                    if (final_write) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state   <= FILL;
                        cluster <= cluster + 1'b1;
                        k       <= '0;
                        pack    <= '0;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memp_load_sequencer.sv
// tb/tb_memp_load_sequencer.sv - scoreboard bench for memp_load_sequencer with a queue-based reference model
module tb_memp_load_sequencer;

    localparam int N  = 9;
    localparam int W  = 64;
    localparam int C  = 3;
    localparam int AW = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [W-1:0]    in_data;
    logic            in_valid;
    logic            in_ready;
    logic [N*W-1:0]  mem_write_data;
    logic            mem_write_enable;
    logic [AW-1:0]   mem_write_address;
    logic            busy;
    logic            done;
`ifdef MEMP_LOADER_FLUSH_EN
    logic            flush;
`endif

    always #5 clk = ~clk;

    memp_load_sequencer #(
        .number_of_clusters(C),
        .number_of_equations_per_cluster(N),
        .element_width(W),
        .address_width(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .in_data(in_data),
        .in_valid(in_valid),
`ifdef MEMP_LOADER_FLUSH_EN
        .flush(flush),
`endif
        .in_ready(in_ready),
        .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable),
        .mem_write_address(mem_write_address),
        .busy(busy),
        .done(done)
    );

    typedef struct {
        bit             is_done;
        bit             after_write;
        logic [AW-1:0]  addr;
        logic [N*W-1:0] data;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] elems[$];
    int           m_cluster;
    int           checks = 0;
    int           passes = 0;
    int           n_writes = 0;
    int           n_dones = 0;
    bit           prev_we = 1'b0;
    exp_t         mon_e;

    task automatic check(input bit ok, input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: element j of a cluster occupies bits [j*W +: W]; unsent slots are zero.
    function automatic logic [N*W-1:0] build_word();
        logic [N*W-1:0] word = '0;
        foreach (elems[j]) word[j*W +: W] = elems[j];
        return word;
    endfunction

    function automatic bit model_accept(input logic [W-1:0] d);
        exp_t e;
        elems.push_back(d);
        if (elems.size() < N) return 1'b0;
        e.is_done = 0; e.after_write = 0; e.addr = AW'(m_cluster); e.data = build_word();
        sb.push_back(e);
        elems.delete();
        m_cluster++;
        if (m_cluster == C) begin
            e.is_done = 1; e.after_write = 1; e.addr = '0; e.data = '0;
            sb.push_back(e);
        end
        return 1'b1;
    endfunction

    function automatic void model_flush();
        exp_t e;
        e.addr = AW'(m_cluster); e.data = build_word();
        if (elems.size() > 0) begin
            e.is_done = 0; e.after_write = 0;
            sb.push_back(e);
        end
        e.is_done = 1; e.after_write = (elems.size() > 0); e.addr = '0; e.data = '0;
        sb.push_back(e);
        elems.delete();
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_write_enable) begin
                n_writes++;
                check(sb.size() != 0 && !sb[0].is_done, "write_expected", 1, 0);
                if (sb.size() != 0 && !sb[0].is_done) begin
                    mon_e = sb.pop_front();
                    check(mem_write_address == mon_e.addr, "write_addr", mem_write_address, mon_e.addr);
                    check(mem_write_data == mon_e.data, "write_data", mem_write_data, mon_e.data);
                end
            end
            if (done) begin
                n_dones++;
                check(sb.size() != 0 && sb[0].is_done, "done_expected", 1, 0);
                if (sb.size() != 0 && sb[0].is_done) begin
                    mon_e = sb.pop_front();
                    check(prev_we == mon_e.after_write, "done_timing", prev_we, mon_e.after_write);
                end
                check(busy == 1'b0, "busy_low_at_done", busy, 0);
            end
            if (!busy) check(in_ready == 1'b0, "in_ready_when_not_busy", in_ready, 0);
            prev_we = mem_write_enable;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic start_load();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        elems.delete();
        m_cluster = 0;
        check(busy == 1'b1, "busy_after_start", busy, 1);
    endtask

    task automatic send(input logic [W-1:0] d, input bit s);
        bit r;
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        start    = s;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            t++;
        end while (!r && t < 50);
        in_valid = 1'b0;
        check(r, "transfer_timeout", t, 50);
        if (r && model_accept(d))
            check(mem_write_enable == 1'b1, "strobe_latency", mem_write_enable, 1);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || sb.size() != 0) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check(t < 200, "load_timeout", t, 200);
    endtask

    task automatic random_load();
        start_load();
        for (int i = 0; i < N*C; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            send({$urandom, $urandom}, 1'b0);
        end
        wait_idle();
    endtask

    int w0, d0;

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = {$urandom, $urandom};
`ifdef MEMP_LOADER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check(in_ready == 0, "rst_in_ready", in_ready, 0);
        check(mem_write_enable == 0, "rst_we", mem_write_enable, 0);
        check(done == 0, "rst_done", done, 0);
        check(busy == 0, "rst_busy", busy, 0);
        check(mem_write_address == 0, "rst_addr", mem_write_address, 0);
        check(mem_write_data == 0, "rst_data", mem_write_data, 0);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check(busy == 0 && in_ready == 0, "idle_with_valid", {busy, in_ready}, 0);
        end
        in_valid = 1'b0;

        // Back-to-back elements 1..27.
        w0 = n_writes; d0 = n_dones;
        start_load();
        for (int i = 1; i <= N*C; i++) send(W'(i), 1'b0);
        wait_idle();
        check(n_writes - w0 == C, "b2b_write_count", n_writes - w0, C);
        check(n_dones - d0 == 1, "b2b_done_count", n_dones - d0, 1);

        // in_valid low every third cycle.
        w0 = n_writes; d0 = n_dones;
        start_load();
        for (int i = 0; i < N*C; i++) begin
            if (i % 3 == 2) idle_cycle();
            send({$urandom, $urandom}, 1'b0);
        end
        wait_idle();
        check(n_writes - w0 == C, "stall_write_count", n_writes - w0, C);
        check(n_dones - d0 == 1, "stall_done_count", n_dones - d0, 1);
        check(busy == 0, "stall_busy_after", busy, 0);

        // Reset after 13 elements aborts; a new load restarts at address 0.
        w0 = n_writes;
        start_load();
        for (int i = 0; i < 13; i++) send({$urandom, $urandom}, 1'b0);
        rst_n = 1'b0;
        elems.delete();
        sb.delete();
        @(posedge clk); #1;
        check(busy == 0 && mem_write_enable == 0, "midrst_outputs", {busy, mem_write_enable}, 0);
        check(mem_write_address == 0, "midrst_addr", mem_write_address, 0);
        rst_n = 1'b1;
        repeat (5) idle_cycle();
        check(n_writes - w0 == 1, "midrst_no_more_writes", n_writes - w0, 1);
        random_load();

        // start pulses in FILL, WRITE and DONE are ignored.
        w0 = n_writes; d0 = n_dones;
        start_load();
        for (int i = 0; i < N*C; i++) begin
            send({$urandom, $urandom}, i == 3);
            if (i == N-1) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
        check(done == 1, "done_cycle", done, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(busy == 0, "start_in_done_ignored", busy, 0);
        check(n_writes - w0 == C, "ignored_start_writes", n_writes - w0, C);
        check(n_dones - d0 == 1, "ignored_start_dones", n_dones - d0, 1);

`ifdef MEMP_LOADER_FLUSH_EN
        // Flush with a partial cluster, then flush at an empty cluster.
        start_load();
        for (int i = 0; i < 12; i++) send({$urandom, $urandom}, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
        check(mem_write_enable == 1, "flush_strobe", mem_write_enable, 1);
        wait_idle();
        start_load();
        for (int i = 0; i < N; i++) send({$urandom, $urandom}, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
        check(done == 1, "flush_empty_done", done, 1);
        wait_idle();
`endif

        repeat (3) random_load();
        check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
